// File: rtl/pll_dyncfg_ctrl.sv
// -----------------------------------------------------------------------------
// pll_dyncfg_ctrl
//
// Master side of the EF2 PLL dynamic-configuration port. On an accepted request
// it holds the PLL in reset, writes one output channel's divider and duty
// registers, commits them with load_reg, releases reset and then qualifies
// extlock (stable-count plus timeout).
//
// Ports
//   refclk, reset          sole clock (rising edge) / async active-high reset
//   cfg_valid, cfg_ready   request handshake
//   cfg_chan, cfg_div      channel 0..4 and divide ratio 1..255
//   daddr, di, dcs, dwe    configuration write port
//   load_reg               one-cycle commit strobe
//   pll_rst                PLL reset
//   extlock                PLL lock, asynchronous to refclk
//   busy                   FSM not in IDLE
//   done, err              one-cycle result pulses
//   locked                 qualified lock status
//
// Request handshake: a request transfers on every rising edge where
// cfg_valid && cfg_ready. cfg_ready is high only in IDLE (and not in the first
// cycle after reset); cfg_chan/cfg_div are sampled on that same edge. Nothing
// is queued: cfg_valid while busy is ignored.
//
// Parameter ranges assumed: RST_CYCLES >= 4, WR_GAP >= 1, both below 256.
// -----------------------------------------------------------------------------
module pll_dyncfg_ctrl #(
  parameter logic [5:0] DIV_ADDR_BASE = 6'h10,
  parameter int         RST_CYCLES    = 8,
  parameter int         WR_GAP        = 2,
  parameter int         LOCK_STABLE   = 16,
  parameter int         LOCK_TIMEOUT  = 4096
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_chan,
  input  logic [7:0] cfg_div,
  output logic [5:0] daddr,
  output logic [7:0] di,
  output logic       dcs,
  output logic       dwe,
  output logic       load_reg,
  output logic       pll_rst,
  input  logic       extlock,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       locked
);

  localparam int CW = 8;
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(WR_GAP - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_WR_DIV,
    S_GAP1,
    S_WR_DUTY,
    S_GAP2,
    S_LOAD,
    S_RELEASE,
    S_WAIT_LOCK
  } state_t;

  state_t state, state_nx;

  // boot_q is high from reset until the first clock edge; it keeps pll_rst
  // asserted and cfg_ready low for that one cycle.
  logic          boot_q;
  logic          ext_s1, lk;
  logic [2:0]    chan_q, chan_nx;
  logic [7:0]    div_q, div_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [SW-1:0] stab_q, stab_nx, stab_inc;
  logic [TW-1:0] tmo_q, tmo_nx, tmo_inc;
  logic [5:0]    daddr_nx;
  logic [7:0]    di_nx;
  logic          done_nx, err_nx, locked_nx;
  logic          accept, legal;
  logic [5:0]    div_addr;

  assign accept   = cfg_valid && cfg_ready;
  assign legal    = (cfg_chan <= 3'd4) && (cfg_div != 8'd0);
  assign div_addr = DIV_ADDR_BASE + {2'b00, chan_q, 1'b0};

  // Saturating run length of consecutive lk=1 cycles.
  assign stab_inc = !lk ? '0 : ((stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1));
  assign tmo_inc  = tmo_q + TW'(1);

  assign cfg_ready = (state == S_IDLE) && !boot_q;
  assign busy      = (state != S_IDLE);
  assign dcs       = (state == S_WR_DIV) || (state == S_WR_DUTY);
  assign dwe       = dcs;
  assign load_reg  = (state == S_LOAD);
  assign pll_rst   = boot_q || (state inside {S_RST_HOLD, S_WR_DIV, S_GAP1,
                                              S_WR_DUTY, S_GAP2, S_LOAD});

  always_comb begin
    state_nx  = state;
    chan_nx   = chan_q;
    div_nx    = div_q;
    cnt_nx    = cnt_q;
    stab_nx   = '0;
    tmo_nx    = '0;
    daddr_nx  = daddr;
    di_nx     = di;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    locked_nx = locked;

    unique case (state)
      S_IDLE: begin
        stab_nx   = stab_inc;
        locked_nx = (stab_inc == STAB_MAX);
        if (accept) begin
          if (legal) begin
            state_nx  = S_RST_HOLD;
            chan_nx   = cfg_chan;
            div_nx    = cfg_div;
            cnt_nx    = '0;
            stab_nx   = '0;
            locked_nx = 1'b0;
          end else begin
            // Illegal request is consumed but only reported.
            err_nx = 1'b1;
          end
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_nx   = '0;
          state_nx = S_WR_DIV;
          daddr_nx = div_addr;
          di_nx    = div_q - 8'd1;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      S_WR_DIV: state_nx = S_GAP1;
      S_GAP1: begin
        if (cnt_q == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_WR_DUTY;
          daddr_nx = div_addr + 6'd1;
          di_nx    = div_q >> 1;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      S_WR_DUTY: state_nx = S_GAP2;
      S_GAP2: begin
        if (cnt_q == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_LOAD;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      S_LOAD: state_nx = S_RELEASE;
      S_RELEASE: begin
        // Timeout counts from the release cycle, so a timeout err lands
        // exactly LOCK_TIMEOUT cycles after RELEASE.
        tmo_nx   = TW'(1);
        state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        stab_nx = stab_inc;
        tmo_nx  = tmo_inc;
        if (stab_inc == STAB_MAX) begin
          // Success takes priority over a simultaneous timeout.
          done_nx   = 1'b1;
          locked_nx = 1'b1;
          state_nx  = S_IDLE;
        end else if (tmo_inc == TMO_MAX) begin
          err_nx    = 1'b1;
          locked_nx = 1'b0;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      boot_q <= 1'b1;
      ext_s1 <= 1'b0;
      lk     <= 1'b0;
      chan_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      stab_q <= '0;
      tmo_q  <= '0;
      daddr  <= '0;
      di     <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nx;
      boot_q <= 1'b0;
      ext_s1 <= extlock;
      lk     <= ext_s1;
      chan_q <= chan_nx;
      div_q  <= div_nx;
      cnt_q  <= cnt_nx;
      stab_q <= stab_nx;
      tmo_q  <= tmo_nx;
      daddr  <= daddr_nx;
      di     <= di_nx;
      done   <= done_nx;
      err    <= err_nx;
      locked <= locked_nx;
    end
  end

endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_dyncfg_ctrl
//
// Directed bench for pll_dyncfg_ctrl. A timeline model (request accept cycle
// plus fixed offsets, lock run length from a delayed copy of extlock) predicts
// every output each cycle; a write scoreboard holds the hand-computed
// {daddr,di} pairs; directed checks pin latencies with literal cycle counts.
// -----------------------------------------------------------------------------
module tb_pll_dyncfg_ctrl;

  localparam int         R      = 8;
  localparam int         G      = 2;
  localparam int         LS     = 16;
  localparam int         TMO    = 4096;
  localparam logic [5:0] BASE   = 6'h10;
  localparam int         REL_K  = R + 2*G + 4;  // RELEASE offset from accept cycle
  localparam int         WAIT_K = R + 2*G + 5;  // first WAIT_LOCK offset

  // ---------------- clock / reset ----------------
  logic       refclk = 1'b0;
  logic       reset  = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_chan  = 3'd0;
  logic [7:0] cfg_div   = 8'd0;
  logic       extlock   = 1'b0;
  logic       cfg_ready, dcs, dwe, load_reg, pll_rst, busy, done, err, locked;
  logic [5:0] daddr;
  logic [7:0] di;

  initial forever #5 refclk = ~refclk;

  pll_dyncfg_ctrl #(
    .DIV_ADDR_BASE(BASE), .RST_CYCLES(R), .WR_GAP(G),
    .LOCK_STABLE(LS), .LOCK_TIMEOUT(TMO)
  ) dut (
    .refclk(refclk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div),
    .daddr(daddr), .di(di), .dcs(dcs), .dwe(dwe), .load_reg(load_reg),
    .pll_rst(pll_rst), .extlock(extlock),
    .busy(busy), .done(done), .err(err), .locked(locked)
  );

  int tb_cyc = 0;
  always @(posedge refclk) tb_cyc <= tb_cyc + 1;

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_booted, m_active, m_done, m_err, m_locked;
  int         m_cyc, m_t0, m_run;
  logic [2:0] m_ch;
  logic [7:0] m_dv;
  logic       e1, lk_cur, lk_used;

  task automatic model_reset();
    m_booted = 0; m_active = 0; m_done = 0; m_err = 0; m_locked = 0;
    m_cyc = 0; m_t0 = 0; m_run = 0; m_ch = '0; m_dv = '0;
    e1 = 0; lk_cur = 0; lk_used = 0;
  endtask

  task automatic model_step();
    int k_old;
    // lk seen by the design this edge = extlock sampled two edges back
    lk_used = lk_cur;
    lk_cur  = e1;
    e1      = extlock;
    m_done  = 0;
    m_err   = 0;
    k_old   = m_cyc - m_t0;
    m_cyc++;
    if (!m_active) begin
      if (m_booted && cfg_valid && cfg_chan <= 3'd4 && cfg_div != 8'd0) begin
        m_active = 1; m_t0 = m_cyc - 1; m_ch = cfg_chan; m_dv = cfg_div;
        m_run = 0; m_locked = 0;
      end else begin
        if (m_booted && cfg_valid) m_err = 1;
        m_run    = lk_used ? m_run + 1 : 0;
        m_locked = (m_run >= LS);
      end
    end else if (k_old >= WAIT_K) begin
      m_run = lk_used ? m_run + 1 : 0;
      if (m_run >= LS) begin
        m_done = 1; m_locked = 1; m_active = 0;
      end else if (m_cyc - m_t0 - REL_K == TMO) begin
        m_err = 1; m_locked = 0; m_active = 0;
      end
    end
    m_booted = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [13:0] exp_q[$];
  logic [13:0] exp_e;
  int n_dcs = 0, n_load = 0, n_done = 0, n_err = 0;
  int last_wr_cyc = 0, prev_wr_cyc = 0, last_load_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;

  initial begin
    int  k;
    bit  wr_now, duty;
    forever begin
      @(negedge refclk);
      k      = m_cyc - m_t0;
      wr_now = m_active && (k == R + 1 || k == R + G + 2);
      chk("busy",      32'(busy),      32'(m_active));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_booted && !m_active));
      chk("pll_rst",   32'(pll_rst),   32'(!m_booted || (m_active && k >= 1 && k <= R + 2*G + 3)));
      chk("dcs",       32'(dcs),       32'(wr_now));
      chk("dwe",       32'(dwe),       32'(wr_now));
      chk("load_reg",  32'(load_reg),  32'(m_active && k == R + 2*G + 3));
      chk("done",      32'(done),      32'(m_done));
      chk("err",       32'(err),       32'(m_err));
      chk("locked",    32'(locked),    32'(m_locked));
      if (m_active && k >= R + 1 && k <= R + 2*G + 2) begin
        duty = (k > R + 1 + G);
        chk("daddr", 32'(daddr), 32'(BASE + 6'(2 * m_ch) + (duty ? 6'd1 : 6'd0)));
        chk("di",    32'(di),    32'(duty ? (m_dv >> 1) : (m_dv - 8'd1)));
      end
      if (dcs) begin
        n_dcs++;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = tb_cyc;
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("wr_addr_data", 32'({daddr, di}), 32'(exp_e));
        end
      end
      if (load_reg) begin n_load++; last_load_cyc = tb_cyc; end
      if (done)     begin n_done++; last_done_cyc = tb_cyc; end
      if (err)      begin n_err++;  last_err_cyc  = tb_cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic send_req(input logic [2:0] ch, input logic [7:0] dv);
    @(posedge refclk); #1;
    cfg_valid = 1'b1; cfg_chan = ch; cfg_div = dv; acc_cyc = tb_cyc;
    @(posedge refclk); #1;
    cfg_valid = 1'b0;
    cfg_chan  = 3'($urandom_range(0, 7));
    cfg_div   = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_load(input int budget);
    int  l0;
    bit  ok;
    l0 = n_load; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge refclk);
      if (n_load != l0) begin ok = 1; break; end
    end
    chk("wait_load_in_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_wr(input int budget);
    int  w0;
    bit  ok;
    w0 = n_dcs; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge refclk);
      if (n_dcs != w0) begin ok = 1; break; end
    end
    chk("wait_wr_in_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_end(input int budget);
    int  d0, e0;
    bit  ok;
    d0 = n_done; e0 = n_err; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge refclk);
      if (n_done != d0 || n_err != e0) begin ok = 1; break; end
    end
    chk("wait_end_in_budget", 32'(ok), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int dcs0, err0, done0, load0, rise_cyc;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_pll_rst",   32'(pll_rst),   32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_dcs",       32'(dcs),       32'd0);
    chk("rst_load_reg",  32'(load_reg),  32'd0);
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_daddr_di",  32'({daddr, di}), 32'd0);
    #24 reset = 1'b0;
    @(posedge refclk); #1;
    chk("boot_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("boot_pll_rst",   32'(pll_rst),   32'd0);
    repeat (3) @(posedge refclk);

    // T1: chan=2 div=32, lock comes up in WAIT_LOCK
    dcs0 = n_dcs;
    exp_q.push_back({6'h14, 8'h1F});
    exp_q.push_back({6'h15, 8'h10});
    send_req(3'd2, 8'd32);
    wait_load(40);
    @(posedge refclk); #1;
    extlock = 1'b1; rise_cyc = tb_cyc;
    wait_end(100);
    #1;
    chk("t1_first_wr_latency", 32'(prev_wr_cyc - acc_cyc), 32'd9);
    chk("t1_wr_spacing",       32'(last_wr_cyc - prev_wr_cyc), 32'd3);
    chk("t1_load_after_wr2",   32'(last_load_cyc - last_wr_cyc), 32'd3);
    chk("t1_done_latency",     32'(last_done_cyc - rise_cyc), 32'd18);
    chk("t1_write_count",      32'(n_dcs - dcs0), 32'd2);
    chk("t1_locked",           32'(locked), 32'd1);

    // T2/T3: illegal requests
    dcs0 = n_dcs; err0 = n_err;
    send_req(3'd5, 8'd8);
    @(posedge refclk); #1;
    chk("t2_err_latency", 32'(last_err_cyc - acc_cyc), 32'd1);
    chk("t2_err_count",   32'(n_err - err0), 32'd1);
    chk("t2_locked_kept", 32'(locked), 32'd1);
    chk("t2_pll_rst",     32'(pll_rst), 32'd0);
    send_req(3'd0, 8'd0);
    @(posedge refclk); #1;
    chk("t3_err_latency", 32'(last_err_cyc - acc_cyc), 32'd1);
    chk("t3_err_count",   32'(n_err - err0), 32'd2);
    chk("t23_no_writes",  32'(n_dcs - dcs0), 32'd0);

    // T4: lock drop in IDLE, then chan=4 div=1 timing out
    @(posedge refclk); #1;
    extlock = 1'b0;
    repeat (3) @(posedge refclk); #1;
    chk("t4_idle_drop", 32'(locked), 32'd0);
    done0 = n_done;
    exp_q.push_back({6'h18, 8'h00});
    exp_q.push_back({6'h19, 8'h00});
    send_req(3'd4, 8'd1);
    wait_load(40);
    wait_end(4200);
    #1;
    chk("t4_timeout_latency", 32'(last_err_cyc - last_load_cyc), 32'd4097);
    chk("t4_no_done",         32'(n_done - done0), 32'd0);
    chk("t4_locked",          32'(locked), 32'd0);
    chk("t4_pll_rst",         32'(pll_rst), 32'd0);

    // T5: lock glitch inside WAIT_LOCK restarts the stable count
    exp_q.push_back({6'h12, 8'h09});
    exp_q.push_back({6'h13, 8'h05});
    send_req(3'd1, 8'd10);
    wait_load(40);
    @(posedge refclk); #1;
    extlock = 1'b1; rise_cyc = tb_cyc;
    repeat (10) @(posedge refclk); #1;
    extlock = 1'b0;
    @(posedge refclk); #1;
    extlock = 1'b1;
    wait_end(100);
    chk("t5_glitch_done_latency", 32'(last_done_cyc - rise_cyc), 32'd29);

    // T6: reset during GAP1 aborts without commit, then a clean request
    load0 = n_load; done0 = n_done; err0 = n_err;
    exp_q.push_back({6'h16, 8'hC7});
    send_req(3'd3, 8'd200);
    wait_wr(40);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_pll_rst", 32'(pll_rst),  32'd1);
    chk("t6_async_dcs_dwe", 32'({dcs, dwe}), 32'd0);
    chk("t6_async_load",    32'(load_reg), 32'd0);
    chk("t6_async_busy",    32'(busy),     32'd0);
    chk("t6_async_ready",   32'(cfg_ready), 32'd0);
    chk("t6_async_pulses",  32'({done, err}), 32'd0);
    repeat (2) @(posedge refclk);
    #3 reset = 1'b0;
    chk("t6_no_second_write", 32'(exp_q.size()), 32'd0);
    chk("t6_no_load",         32'(n_load - load0), 32'd0);
    chk("t6_no_done_err",     32'((n_done - done0) + (n_err - err0)), 32'd0);
    @(posedge refclk); #1;
    chk("t6_ready_after_reset", 32'(cfg_ready), 32'd1);
    exp_q.push_back({6'h14, 8'h1F});
    exp_q.push_back({6'h15, 8'h10});
    send_req(3'd2, 8'd32);
    wait_load(40);
    wait_end(100);
    #1;
    chk("t6_fresh_done", 32'(n_done - done0), 32'd1);
    chk("t6_fresh_locked", 32'(locked), 32'd1);

    repeat (3) @(posedge refclk);
    chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d bad", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
